// File: rtl/retirement_map_freelist_if.sv
// Bundles the rename/commit-side signals of the retirement map and free list.
// Latency: none, wiring only.
// Backpressure: none; rename stalls itself when free_empty is high.
interface retirement_map_freelist_if #(
    parameter int PHYS_REG_ADDR = 6,
    parameter int ARCH_REGS     = 32
);
    logic                                      flush;
    logic                                      commit_valid;
    logic [4:0]                                commit_rd_addr;
    logic [PHYS_REG_ADDR-1:0]                  commit_phys_addr;
    logic                                      alloc_req;
    logic [PHYS_REG_ADDR-1:0]                  free_phys_addr;
    logic                                      free_empty;
    logic [5:0]                                free_count;
    logic [ARCH_REGS-1:0][PHYS_REG_ADDR-1:0]   rrf_state;
    logic [PHYS_REG_ADDR-1:0]                  freed_phys_addr;

    // Driven by the ROB / rename side.
    modport master (
        output flush, commit_valid, commit_rd_addr, commit_phys_addr, alloc_req,
        input  free_phys_addr, free_empty, free_count, rrf_state, freed_phys_addr
    );

    // Implemented by the retirement map / free list.
    modport slave (
        input  flush, commit_valid, commit_rd_addr, commit_phys_addr, alloc_req,
        output free_phys_addr, free_empty, free_count, rrf_state, freed_phys_addr
    );
endinterface

// File: rtl/retirement_map_freelist.sv
// Retirement register map plus circular physical-register free list with flush rollback.
// Latency: state updates on the clock edge; outputs are combinational from registered state.
// Backpressure: none; alloc while empty is dropped, so rename must stall on free_empty.
module retirement_map_freelist #(
    parameter int PHYS_REGSIZE  = 64,
    parameter int PHYS_REG_ADDR = $clog2(PHYS_REGSIZE),
    parameter int ARCH_REGS     = 32,
    parameter int FL_DEPTH      = PHYS_REGSIZE - ARCH_REGS
) (
    input logic                       clk,
    input logic                       rst,
    retirement_map_freelist_if.slave  bus
);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int IDX_W = $clog2(FL_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [ARCH_REGS-1:0][PHYS_REG_ADDR-1:0] rrf_q, rrf_d;
    logic [FL_DEPTH-1:0][PHYS_REG_ADDR-1:0]  fl_buf_q, fl_buf_d;
    logic [PTR_W-1:0]                        head_q, head_d;
    logic [PTR_W-1:0]                        tail_q, tail_d;
    logic [PTR_W-1:0]                        ret_head_q, ret_head_d;
    logic [PHYS_REG_ADDR-1:0]                freed_q, freed_d;

    logic [PTR_W-1:0]         count;
    logic                     empty;
    logic                     do_alloc;
    logic                     do_commit;
    logic [PHYS_REG_ADDR-1:0] old_map;

    assign count = tail_q - head_q;
    assign empty = (count == '0);

    assign bus.free_phys_addr  = fl_buf_q[head_q[IDX_W-1:0]];
    assign bus.free_count      = count;
    assign bus.free_empty      = empty;
    assign bus.rrf_state       = rrf_q;
    assign bus.freed_phys_addr = freed_q;

    // Next-state: speculative pop, in-order commit push, and flush rollback of head.
    always_comb begin
        rrf_d      = rrf_q;
        fl_buf_d   = fl_buf_q;
        head_d     = head_q;
        tail_d     = tail_q;
        ret_head_d = ret_head_q;
        freed_d    = freed_q;

        do_alloc  = bus.alloc_req && !empty && !bus.flush;
        do_commit = bus.commit_valid && (bus.commit_rd_addr != 5'd0) && !bus.flush;
        old_map   = rrf_q[bus.commit_rd_addr];

        if (do_alloc) begin
            head_d = head_q + 1'b1;
        end

        // The superseded mapping goes back on the tail; the committed pop
        // pointer follows because this instruction's register is now architectural.
        if (do_commit) begin
            rrf_d[bus.commit_rd_addr]  = bus.commit_phys_addr;
            fl_buf_d[tail_q[IDX_W-1:0]] = old_map;
            tail_d                      = tail_q + 1'b1;
            ret_head_d                  = ret_head_q + 1'b1;
            freed_d                     = old_map;
        end

        // Every register popped since the last commit becomes free again.
        if (bus.flush) begin
            head_d = ret_head_q;
        end
    end

    // State register with synchronous active-low reset to the identity map.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rrf_q[i] <= PHYS_REG_ADDR'(i);
            end
            for (int j = 0; j < FL_DEPTH; j++) begin
                fl_buf_q[j] <= PHYS_REG_ADDR'(ARCH_REGS + j);
            end
            head_q     <= '0;
            ret_head_q <= '0;
            tail_q     <= PTR_W'(FL_DEPTH);
            freed_q    <= '0;
        end else begin
            rrf_q      <= rrf_d;
            fl_buf_q   <= fl_buf_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            ret_head_q <= ret_head_d;
            freed_q    <= freed_d;
        end
    end
endmodule

// File: tb/tb_retirement_map_freelist.sv
// Self-checking bench: directed scenarios then random alloc/commit/flush against a queue model.
// Latency: outputs checked 1ns after each rising edge.
// Backpressure: the stimulus only commits when a register is in flight.
module tb_retirement_map_freelist;
    logic clk;
    logic rst;

    retirement_map_freelist_if bus ();

    retirement_map_freelist dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model: the committed free list as a queue (ret_head..tail),
    // with the first m_inflight entries handed out speculatively.
    int m_rrf [32];
    int m_fl [$];
    int m_inflight;
    int m_freed;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rrf[i] = i;
        m_fl.delete();
        for (int j = 0; j < 32; j++) m_fl.push_back(32 + j);
        m_inflight = 0;
        m_freed    = 0;
    endtask

    task automatic model_update(input bit a, input bit cv, input int rd, input int ph,
                                input bit f, input bit r);
        int free_before;
        int old;
        if (!r) begin
            model_reset();
        end else if (f) begin
            m_inflight = 0;
        end else begin
            free_before = m_fl.size() - m_inflight;
            if (a && free_before > 0) m_inflight++;
            if (cv && rd != 0) begin
                old = m_rrf[rd];
                m_rrf[rd] = ph;
                m_fl.push_back(old);
                void'(m_fl.pop_front());
                m_inflight--;
                m_freed = old;
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0][5:0] exp_rrf;
        int  cnt;
        bit  head_mapped;
        cnt = m_fl.size() - m_inflight;
        for (int i = 0; i < 32; i++) exp_rrf[i] = 6'(m_rrf[i]);
        chk("free_count", bus.free_count, cnt);
        chk("free_empty", bus.free_empty, (cnt == 0));
        chk("freed_phys_addr", bus.freed_phys_addr, m_freed);
        chk("rrf_state", bus.rrf_state, exp_rrf);
        if (cnt > 0) begin
            chk("free_phys_addr", bus.free_phys_addr, m_fl[m_inflight]);
            head_mapped = 1'b0;
            for (int i = 0; i < 32; i++)
                if (bus.rrf_state[i] == bus.free_phys_addr) head_mapped = 1'b1;
            chk("head_not_mapped", head_mapped, 1'b0);
        end
    endtask

    // One clock: drive, take the edge, advance the model, then check.
    task automatic step(input bit a, input bit cv, input int rd, input int ph,
                        input bit f, input bit r);
        bus.alloc_req        = a;
        bus.commit_valid     = cv;
        bus.commit_rd_addr   = 5'(rd);
        bus.commit_phys_addr = 6'(ph);
        bus.flush            = f;
        rst                  = r;
        @(posedge clk);
        #1;
        model_update(a, cv, rd, ph, f, r);
        bus.alloc_req    = 1'b0;
        bus.commit_valid = 1'b0;
        bus.flush        = 1'b0;
        rst              = 1'b1;
        compare_all();
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [5:0] cnt_snap;
        int a, cv, rd, f, r;
        checks   = 0;
        failures = 0;
        model_reset();
        bus.alloc_req        = 1'b0;
        bus.commit_valid     = 1'b0;
        bus.commit_rd_addr   = '0;
        bus.commit_phys_addr = '0;
        bus.flush            = 1'b0;
        rst                  = 1'b0;

        // Reset then idle.
        do_reset();
        step(0, 0, 0, 0, 0, 1);
        chk("reset_count", bus.free_count, 32);
        chk("reset_head", bus.free_phys_addr, 32);
        chk("reset_empty", bus.free_empty, 0);
        chk("reset_freed", bus.freed_phys_addr, 0);
        chk("reset_rrf31", bus.rrf_state[31], 31);

        // Three allocations, then commit rd=5 with phys 32.
        step(1, 0, 0, 0, 0, 1);
        chk("alloc1_head", bus.free_phys_addr, 33);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        chk("alloc3_head", bus.free_phys_addr, 35);
        chk("alloc3_count", bus.free_count, 29);
        step(0, 1, 5, 32, 0, 1);
        chk("commit5_rrf", bus.rrf_state[5], 32);
        chk("commit5_freed", bus.freed_phys_addr, 5);
        chk("commit5_count", bus.free_count, 30);

        // Drain the list completely, allocate into empty, then free one.
        do_reset();
        for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 0, 1);
        chk("drain_empty", bus.free_empty, 1);
        chk("drain_count", bus.free_count, 0);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        chk("empty_alloc_count", bus.free_count, 0);
        step(0, 1, 1, 32, 0, 1);
        chk("refill_count", bus.free_count, 1);
        chk("refill_head", bus.free_phys_addr, 1);

        // Allocate four, commit one, flush.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1);
        step(0, 1, 7, 32, 0, 1);
        step(1, 1, 9, 33, 1, 1);
        chk("flush_count", bus.free_count, 32);
        chk("flush_head", bus.free_phys_addr, 33);
        chk("flush_rrf7", bus.rrf_state[7], 32);
        chk("flush_rrf9", bus.rrf_state[9], 9);

        // Steady alloc+commit on rd=3 across pointer wrap.
        do_reset();
        step(1, 0, 0, 0, 0, 1);
        cnt_snap = bus.free_count;
        for (int i = 0; i < 100; i++) step(1, 1, 3, m_fl[0], 0, 1);
        chk("steady_count", bus.free_count, cnt_snap);

        // Commit to x0 changes nothing.
        step(0, 1, 0, 0, 0, 1);
        chk("x0_count", bus.free_count, cnt_snap);
        chk("x0_rrf0", bus.rrf_state[0], 0);

        // Reset dominates simultaneous alloc/commit/flush.
        step(1, 1, 3, m_fl[0], 1, 0);
        chk("midrst_count", bus.free_count, 32);
        chk("midrst_head", bus.free_phys_addr, 32);
        chk("midrst_rrf3", bus.rrf_state[3], 3);
        chk("midrst_freed", bus.freed_phys_addr, 0);

        // Random traffic with only legal commits (a register must be in flight).
        for (int n = 0; n < 3000; n++) begin
            a  = ($urandom_range(0, 99) < 60) ? 1 : 0;
            cv = (m_inflight > 0 && $urandom_range(0, 99) < 50) ? 1 : 0;
            rd = (cv != 0 && $urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 31));
            f  = ($urandom_range(0, 99) < 3) ? 1 : 0;
            r  = ($urandom_range(0, 499) == 0) ? 0 : 1;
            step(a[0], cv[0], rd, (m_inflight > 0) ? m_fl[0] : 0, f[0], r[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
